// File: rtl/river_ctrl.sv
// river_ctrl: farmer/cabbage/goat/wolf crossing controller feeding the external safety checker.
module river_ctrl #(
    parameter int MOVE_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              move,
    input  logic [1:0]        sel,
    input  logic              r,
    output logic              f,
    output logic              c,
    output logic              g,
    output logic              w,
    output logic [MOVE_W-1:0] moves,
    output logic              won,
    output logic              lost,
    output logic              illegal
);
    typedef enum logic [1:0] {PLAY, CHECK, LOST, WON} state_t;
    state_t            state_q;
    logic [3:0]        pos_q;
    logic [MOVE_W-1:0] moves_q;
    logic              move_q, won_q, lost_q, illegal_q;
    logic              req, legal;
    logic [3:0]        toggle;
    assign req    = move & ~move_q;
    // Bit 0 is the farmer, so sel=00 names the farmer himself and is always legal.
    assign legal  = pos_q[sel] == pos_q[0];
    assign toggle = 4'b0001 | (4'b0001 << sel);
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= PLAY;
            pos_q     <= '0;
            moves_q   <= '0;
            move_q    <= 1'b0;
            won_q     <= 1'b0;
            lost_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            move_q    <= move;
            illegal_q <= 1'b0;
            case (state_q)
                PLAY: if (req) begin
                    if (legal) begin
                        pos_q   <= pos_q ^ toggle;
                        moves_q <= &moves_q ? moves_q : moves_q + MOVE_W'(1);
                        state_q <= CHECK;
                    end else begin
                        illegal_q <= 1'b1;
                    end
                end
                CHECK: begin
                    state_q <= r ? LOST : &pos_q ? WON : PLAY;
                    lost_q  <= r;
                    won_q   <= ~r & (&pos_q);
                end
                default: ;
            endcase
        end
    end
    assign {w, g, c, f} = pos_q;
    assign moves   = moves_q;
    assign won     = won_q;
    assign lost    = lost_q;
    assign illegal = illegal_q;
endmodule

// File: tb/tb_river_ctrl.sv
// tb_river_ctrl: directed plus random stimulus against a rule-level game model.
module tb_river_ctrl;
    logic       clk = 1'b0, reset = 1'b1, move = 1'b0, r;
    logic [1:0] sel = 2'b00;
    logic       f, c, g, w, won, lost, illegal;
    logic [4:0] moves;
    int         checks = 0, failures = 0;
    bit         mb[4];
    int         mm;
    bit         mpend, mwon, mlost, mill, mprev;

    always #5 clk = ~clk;

    // Stand-in for the downstream checker: goat left with cabbage or wolf, farmer away.
    assign r = (g != f) && (g == c || g == w);

    river_ctrl #(.MOVE_W(5)) dut (
        .clk(clk), .reset(reset), .move(move), .sel(sel), .r(r),
        .f(f), .c(c), .g(g), .w(w), .moves(moves),
        .won(won), .lost(lost), .illegal(illegal)
    );

    function automatic bit m_unsafe();
        return mb[2] != mb[0] && (mb[2] == mb[1] || mb[2] == mb[3]);
    endfunction

    function automatic logic [11:0] m_exp();
        return {mb[0], mb[1], mb[2], mb[3], 5'(mm), mwon, mlost, mill};
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit rs, input bit mv, input logic [1:0] s);
        bit req;
        reset = rs;
        move  = mv;
        sel   = s;
        @(posedge clk);
        if (rs) begin
            mb = '{default: 1'b0};
            mm = 0;
            {mpend, mwon, mlost, mill, mprev} = '0;
        end else begin
            req   = mv && !mprev;
            mprev = mv;
            mill  = 1'b0;
            if (mpend) begin
                mpend = 1'b0;
                if (m_unsafe()) mlost = 1'b1;
                else if (mb[0] && mb[1] && mb[2] && mb[3]) mwon = 1'b1;
            end else if (!mwon && !mlost && req) begin
                if (mb[s] != mb[0]) mill = 1'b1;
                else begin
                    mb[0] = !mb[0];
                    if (s != 2'd0) mb[s] = !mb[s];
                    mm    = mm < 31 ? mm + 1 : 31;
                    mpend = 1'b1;
                end
            end
        end
        #1;
        chk("cycle", {f, c, g, w, moves, won, lost, illegal}, m_exp());
    endtask

    task automatic pulse(input logic [1:0] s);
        cyc(1'b0, 1'b1, s);
        cyc(1'b0, 1'b0, s);
        cyc(1'b0, 1'b0, s);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 2'd0);
        cyc(1'b0, 1'b0, 2'd0);
    endtask

    initial begin
        logic [1:0] sol[7] = '{2'd2, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd2};
        do_reset();
        chk("reset", {f, c, g, w, moves, won, lost, illegal}, 12'h000);

        foreach (sol[i]) pulse(sol[i]);
        chk("solution_won", {f, c, g, w, moves, won, lost, illegal}, {4'b1111, 5'd7, 3'b100});
        pulse(2'd2);
        chk("won_terminal", {f, c, g, w, moves, won, lost, illegal}, {4'b1111, 5'd7, 3'b100});

        do_reset();
        pulse(2'd0);
        chk("unsafe_lost", {f, c, g, w, moves, won, lost, illegal}, {4'b1000, 5'd1, 3'b010});
        pulse(2'd2);
        chk("lost_terminal", {f, c, g, w, moves, won, lost, illegal}, {4'b1000, 5'd1, 3'b010});

        do_reset();
        pulse(2'd2);
        cyc(1'b0, 1'b1, 2'd1);
        chk("illegal_pulse", {f, c, g, w, moves, won, lost, illegal}, {4'b1010, 5'd1, 3'b001});
        cyc(1'b0, 1'b0, 2'd1);
        chk("illegal_drop", {f, c, g, w, moves, won, lost, illegal}, {4'b1010, 5'd1, 3'b000});
        pulse(2'd0);
        chk("play_after_illegal", {f, c, g, w, moves, won, lost, illegal}, {4'b0010, 5'd2, 3'b000});

        do_reset();
        repeat (20) cyc(1'b0, 1'b1, 2'd2);
        chk("held_button", {f, c, g, w, moves, won, lost, illegal}, {4'b1010, 5'd1, 3'b000});
        cyc(1'b0, 1'b0, 2'd2);
        repeat (40) pulse(2'd2);
        chk("saturate", {f, c, g, w, moves, won, lost, illegal}, {4'b1010, 5'd31, 3'b000});
        pulse(2'd2);
        chk("saturate_pos", {f, c, g, w, moves, won, lost, illegal}, {4'b0000, 5'd31, 3'b000});

        do_reset();
        cyc(1'b0, 1'b1, 2'd0);
        cyc(1'b1, 1'b0, 2'd0);
        chk("reset_in_check", {f, c, g, w, moves, won, lost, illegal}, 12'h000);
        cyc(1'b0, 1'b0, 2'd0);
        chk("no_late_lost", {f, c, g, w, moves, won, lost, illegal}, 12'h000);
        pulse(2'd2);
        chk("after_reset_move", {f, c, g, w, moves, won, lost, illegal}, {4'b1010, 5'd1, 3'b000});

        cyc(1'b0, 1'b0, 2'd0);
        cyc(1'b1, 1'b1, 2'd2);
        chk("reset_vs_req", {f, c, g, w, moves, won, lost, illegal}, 12'h000);
        cyc(1'b0, 1'b0, 2'd2);
        chk("reset_vs_req_next", {f, c, g, w, moves, won, lost, illegal}, 12'h000);

        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 59) == 0, 1'($urandom), 2'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/river_ctrl.md
# river_ctrl

Sequential game controller for the farmer/cabbage/goat/wolf river-crossing lab. It is the stage directly upstream of the combinational safety checker. It holds the bank position of each item and applies player move requests. It drives the checker's f, c, g, w inputs, reads back the checker's unsafe flag r, and from that flag decides loss, win, or continue. It also counts accepted moves.

## Interface
Parameters:
- MOVE_W, default 5, width of the move counter, which saturates at 2^MOVE_W-1.

Ports:
- clk — in — 1 — system clock; all state changes on rising edge.
- reset — in — 1 — one clock; reset is synchronous and active-high.
- move — in — 1 — move button, level; one request per 0→1 edge.
- sel — in — 2 — passenger: 00 alone, 01 cabbage, 10 goat, 11 wolf.
- r — in — 1 — unsafe flag from the downstream checker, combinational on f, c, g, w.
- f, c, g, w — out — 1 each — bank positions; 0 = start bank, 1 = far bank; registered.
- moves — out — MOVE_W — accepted-move count; registered.
- won — out — 1 — high while in the WON state.
- lost — out — 1 — high while in the LOST state.
- illegal — out — 1 — one-cycle pulse when a request is rejected.

## Operation
- Edge detector:
  - Register move_d <= move every cycle, including in non-PLAY states.
  - req = move & ~move_d.
  - move_d resets to 0.
- FSM states: PLAY, CHECK, LOST, WON; the state register holds a 2-bit encoding.
  - PLAY with req=0 → stays in PLAY.
  - PLAY with req=1 and a legal move:
    - Farmer toggles.
    - The selected passenger, if any, toggles.
    - moves increments.
    - Next state is CHECK.
  - PLAY with req=1 and an illegal move:
    - Illegal means the passenger's current position ≠ f.
    - No position change and no count.
    - illegal=1 for one cycle.
    - Stays in PLAY.
  - CHECK: samples r, which reflects the updated positions.
    - r=1 → LOST.
    - Else if f&c&g&w = 1 → WON.
    - Else → PLAY.
  - LOST and WON are terminal; only reset leaves them.
  - req in CHECK, LOST or WON is ignored. It is not queued and does not raise illegal.
- Counter:
  - moves increments only on accepted moves.
  - It saturates at all-ones: at max it holds, and positions still update.
- Reset, valid in any state including mid-CHECK:
  - f=c=g=w=0, moves=0, state=PLAY.
  - won=0, lost=0, illegal=0, move_d=0.
- sel is sampled only in the cycle where req=1.

## Timing
- Cycle T, state PLAY, req=1 and legal: positions and moves update at the T edge and are visible in T+1; state=CHECK in T+1.
- Cycle T+1: r is evaluated on the new positions; the state decision takes effect at the T+1 edge.
- won/lost rise in T+2, i.e. two cycles after the request edge.
- Earliest next accepted request is cycle T+2, so the move rate is at most one per 2 cycles.
- illegal is asserted in T+1 for a request rejected in T, and is low again in T+2.
- Held button (move=1 for many cycles) produces exactly one request.
- reset has priority over req in the same cycle. No request is applied; all outputs are at reset values in the next cycle.
- r is ignored in every state except CHECK.

## Test plan
- **Optimal solution.** Requests with sel = 10, 00, 11, 10, 01, 00, 10, each as a 0→1 pulse spaced ≥3 cycles apart → after the last request, f=c=g=w=1 and moves=7. won=1 two cycles after the final request edge; lost stays 0.
- **Unsafe first move.** Request with sel=00 from reset → f=1, c=g=w=0; the checker drives r=1; lost=1 in T+2, moves=1. A further request → no change.
- **Illegal passenger.** From reset, goat across (f=1, g=1), then a request with sel=01 (cabbage still on bank 0) → illegal pulses for exactly one cycle. Positions stay f=1, c=0, g=1, w=0; moves stays 1; state stays PLAY.
- **Held button and saturation.**
  - Hold move=1 for 20 cycles with sel=10 → exactly one move.
  - Then alternate goat across/back for 40 pulses → all states safe, moves saturates at 31 and holds; g toggles on every accepted move.
- **Reset mid-operation.** Assert reset in the CHECK cycle after a losing move → next cycle f=c=g=w=0, moves=0, lost=0, state=PLAY. A request with sel=10 is then accepted normally.
- **Reset vs. request collision.** reset=1 in the same cycle as a move edge → no move applied and all outputs at reset values.
